// File: rtl/aa_window_gen_if.sv
// Stream interface for aa_window_gen: pixel input stream and cross-window output stream.
// Optional AA_EDGE_FLAG_EN adds the threshold input th and the m_edge output flag.
interface aa_window_gen_if #(
   parameter int PIX_W = 8,
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
);
   logic                       s_valid;
   logic                       s_ready;
   logic [PIX_W-1:0]           s_pix;
   logic                       m_valid;
   logic                       m_ready;
   logic [PIX_W-1:0]           m_center;
   logic [PIX_W-1:0]           m_up;
   logic [PIX_W-1:0]           m_down;
   logic [PIX_W-1:0]           m_left;
   logic [PIX_W-1:0]           m_right;
   logic                       m_border;
   logic [$clog2(IMG_H)-1:0]   m_row;
   logic [$clog2(IMG_W)-1:0]   m_col;
   logic                       m_last;
`ifdef AA_EDGE_FLAG_EN
   logic [PIX_W-1:0]           th;
   logic                       m_edge;

   modport master (
      output s_valid, s_pix, m_ready, th,
      input  s_ready, m_valid, m_center, m_up, m_down, m_left, m_right,
             m_border, m_row, m_col, m_last, m_edge
   );
   modport slave (
      input  s_valid, s_pix, m_ready, th,
      output s_ready, m_valid, m_center, m_up, m_down, m_left, m_right,
             m_border, m_row, m_col, m_last, m_edge
   );
`else
   modport master (
      output s_valid, s_pix, m_ready,
      input  s_ready, m_valid, m_center, m_up, m_down, m_left, m_right,
             m_border, m_row, m_col, m_last
   );
   modport slave (
      input  s_valid, s_pix, m_ready,
      output s_ready, m_valid, m_center, m_up, m_down, m_left, m_right,
             m_border, m_row, m_col, m_last
   );
`endif
endinterface

// File: rtl/aa_window_gen.sv
// Streaming cross-window generator: raster pixels in, centre + up/down/left/right out, borders replicated.
// Optional feature macro AA_EDGE_FLAG_EN adds a registered threshold edge flag (m_edge).
module aa_window_gen #(
   parameter int PIX_W = 8,
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input logic            clk,
   input logic            reset_n,
   aa_window_gen_if.slave bus
);
   localparam int N_PIX = IMG_W * IMG_H;
   localparam int IW    = $clog2(N_PIX);
   localparam int RW    = $clog2(IMG_H);
   localparam int CW    = $clog2(IMG_W);
   localparam int HD    = 2 * IMG_W + 1;

   localparam logic [1:0] ST_FILL  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]       r_state;
   logic [IW-1:0]    r_in_idx;
   logic [RW-1:0]    r_ld_row;
   logic [CW-1:0]    r_ld_col;
   logic [PIX_W-1:0] r_hist [HD];

   logic             r_m_valid;
   logic [PIX_W-1:0] r_m_center, r_m_up, r_m_down, r_m_left, r_m_right;
   logic             r_m_border;
   logic [RW-1:0]    r_m_row;
   logic [CW-1:0]    r_m_col;
   logic             r_m_last;

   logic             w_s_ready;
   logic             w_out_free;
   logic             w_in_fire;
   logic             w_flush_load;
   logic             w_load;
   logic             w_frame_done;
   logic             w_top, w_bot, w_lft, w_rgt;
   logic [PIX_W-1:0] w_ctr, w_up, w_down, w_left, w_right;

   assign w_out_free = !r_m_valid | bus.m_ready;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_s_ready = 1'b0;
      case (r_state)
         ST_FILL: w_s_ready = 1'b1;
         ST_RUN:  w_s_ready = w_out_free;
         default: w_s_ready = 1'b0;
      endcase
   end

   assign w_in_fire    = bus.s_valid & w_s_ready;
   assign w_flush_load = (r_state == ST_FLUSH) & w_out_free & !(r_m_valid & r_m_last);
   assign w_load       = ((r_state == ST_RUN) & w_in_fire) | w_flush_load;
   assign w_frame_done = (r_state == ST_FLUSH) & r_m_valid & r_m_last & bus.m_ready;

   // History slot j holds the pixel accepted j+1 inputs ago; the window centre sits IMG_W slots back.
   assign w_top   = (r_ld_row == '0);
   assign w_bot   = (r_ld_row == RW'(IMG_H - 1));
   assign w_lft   = (r_ld_col == '0);
   assign w_rgt   = (r_ld_col == CW'(IMG_W - 1));
   assign w_ctr   = r_hist[IMG_W];
   assign w_up    = w_top ? w_ctr : r_hist[2 * IMG_W];
   assign w_down  = w_bot ? w_ctr : r_hist[0];
   assign w_left  = w_lft ? w_ctr : r_hist[IMG_W + 1];
   assign w_right = w_rgt ? w_ctr : r_hist[IMG_W - 1];

   // NOTE: the history is pure data storage and is deliberately left out of reset;
   // border replication guarantees stale entries never reach an output.
   always_ff @(posedge clk) begin
      if (w_in_fire | w_flush_load) begin
         r_hist[0] <= bus.s_pix;
         for (int i = 1; i < HD; i++) r_hist[i] <= r_hist[i-1];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= ST_FILL;
         r_in_idx   <= '0;
         r_ld_row   <= '0;
         r_ld_col   <= '0;
         r_m_valid  <= 1'b0;
         r_m_center <= '0;
         r_m_up     <= '0;
         r_m_down   <= '0;
         r_m_left   <= '0;
         r_m_right  <= '0;
         r_m_border <= 1'b0;
         r_m_row    <= '0;
         r_m_col    <= '0;
         r_m_last   <= 1'b0;
      end else begin
         case (r_state)
            ST_FILL: if (w_in_fire) begin
               r_in_idx <= r_in_idx + 1'b1;
               if (r_in_idx == IW'(IMG_W)) r_state <= ST_RUN;
            end
            ST_RUN: if (w_in_fire) begin
               if (r_in_idx == IW'(N_PIX - 1)) r_state  <= ST_FLUSH;
               else                            r_in_idx <= r_in_idx + 1'b1;
            end
            ST_FLUSH: if (w_frame_done) begin
               r_state  <= ST_FILL;
               r_in_idx <= '0;
            end
            default: r_state <= ST_FILL;
         endcase

         if (w_load) begin
            r_m_valid  <= 1'b1;
            r_m_center <= w_ctr;
            r_m_up     <= w_up;
            r_m_down   <= w_down;
            r_m_left   <= w_left;
            r_m_right  <= w_right;
            r_m_border <= w_top | w_bot | w_lft | w_rgt;
            r_m_row    <= r_ld_row;
            r_m_col    <= r_ld_col;
            r_m_last   <= w_bot & w_rgt;
            if (w_rgt) begin
               r_ld_col <= '0;
               if (!w_bot) r_ld_row <= r_ld_row + 1'b1;
            end else begin
               r_ld_col <= r_ld_col + 1'b1;
            end
         end else if (bus.m_ready) begin
            r_m_valid <= 1'b0;
         end

         if (w_frame_done) begin
            r_ld_row <= '0;
            r_ld_col <= '0;
         end
      end
   end

`ifdef AA_EDGE_FLAG_EN
   logic r_m_edge;
   logic w_edge;

   assign w_edge = (w_ctr > bus.th) &
                   ((w_up < bus.th) | (w_down < bus.th) | (w_left < bus.th) | (w_right < bus.th));

   always_ff @(posedge clk) begin
      if (!reset_n)    r_m_edge <= 1'b0;
      else if (w_load) r_m_edge <= w_edge;
   end

   assign bus.m_edge = r_m_edge;
`else
`endif

   assign bus.s_ready  = w_s_ready;
   assign bus.m_valid  = r_m_valid;
   assign bus.m_center = r_m_center;
   assign bus.m_up     = r_m_up;
   assign bus.m_down   = r_m_down;
   assign bus.m_left   = r_m_left;
   assign bus.m_right  = r_m_right;
   assign bus.m_border = r_m_border;
   assign bus.m_row    = r_m_row;
   assign bus.m_col    = r_m_col;
   assign bus.m_last   = r_m_last;

endmodule
